// File: rtl/aes_shift_rows_if.sv
// Beat-level handshake bundle for the ShiftRows pipeline stage.
// The slave side is the stage itself; the master side is the upstream/downstream pair.
interface aes_shift_rows_if #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic                in_inv;
  logic [TAG_W-1:0]    in_tag;
  logic [32*NB-1:0]    in_state;
  logic                out_valid;
  logic                out_ready;
  logic [32*NB-1:0]    out_state;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_inv, in_tag, in_state, out_ready,
    input  in_ready, out_valid, out_state, out_tag
  );

  modport slave (
    input  in_valid, in_inv, in_tag, in_state, out_ready,
    output in_ready, out_valid, out_state, out_tag
  );
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for 4/6/8-column Rijndael states.
// Permutation is wiring on the input side; a 2-entry elastic buffer holds result + tag.
module aes_shift_rows_pipe #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_shift_rows_if.slave  bus
);

  localparam int unsigned SW = 32 * NB;
  localparam int unsigned EW = SW + TAG_W;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be at least 1");
  end

  // Row offsets: 256-bit blocks shift rows 2/3 by one extra column.
  function automatic int unsigned shift_amt(input int unsigned r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [SW-1:0] fwd_c;
  logic [SW-1:0] inv_c;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned S  = shift_amt(r);
      localparam int unsigned FS = (c + S) % NB;
      localparam int unsigned IS = (c + NB - S) % NB;
      assign fwd_c[SW-1-8*(4*c+r) -: 8] = bus.in_state[SW-1-8*(4*FS+r) -: 8];
      assign inv_c[SW-1-8*(4*c+r) -: 8] = bus.in_state[SW-1-8*(4*IS+r) -: 8];
    end
  end

  logic [EW-1:0] in_entry_c;
  assign in_entry_c = {bus.in_tag, (bus.in_inv ? inv_c : fwd_c)};

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} occ_e;

  occ_e          state_q, state_d;
  logic          in_ready_q, out_valid_q;
  logic [EW-1:0] head_q, tail_q;
  logic          push_c, pop_c;
  logic          head_load, head_from_tail, tail_load;

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  // Occupancy register; handshake flags are decoded from the next occupancy so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (push_c) state_d = S_ONE;
      S_ONE: begin
        if (push_c && !pop_c)      state_d = S_FULL;
        else if (!push_c && pop_c) state_d = S_EMPTY;
      end
      S_FULL:  if (pop_c) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Entry load controls: head is always the oldest beat, tail only fills when head is occupied.
  always_comb begin
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    unique case (state_q)
      S_EMPTY: head_load = push_c;
      S_ONE: begin
        if (push_c && pop_c) head_load = 1'b1;
        else if (push_c)     tail_load = 1'b1;
      end
      S_FULL:  head_from_tail = pop_c;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (head_from_tail) head_q <= tail_q;
      else if (head_load) head_q <= in_entry_c;
      if (tail_load)      tail_q <= in_entry_c;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = head_q[SW-1:0];
  assign bus.out_tag   = head_q[EW-1:SW];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Randomised and directed bench for aes_shift_rows_pipe at NB=4 and NB=8 against a queue model.
module tb_aes_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_shift_rows_if #(.NB(4), .TAG_W(4)) if4 ();
  aes_shift_rows_if #(.NB(8), .TAG_W(4)) if8 ();

  aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   tag;
    logic [127:0] e4;
    logic [255:0] e8;
  } exp_t;

  exp_t       q[$];
  logic [3:0] popped[$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference ShiftRows: out[r][c] = in[r][(c +/- s(r)) mod nb], state right-aligned in 256 bits.
  function automatic logic [255:0] ref_sr(input int nb, input logic [255:0] st, input logic inv);
    logic [7:0]   b [32];
    logic [255:0] res;
    int           s, src;
    res = '0;
    for (int k = 0; k < 4*nb; k++) b[k] = st[32*nb-1-8*k -: 8];
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        s   = (nb == 8 && r >= 2) ? r + 1 : r;
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        res[32*nb-1-8*(4*c+r) -: 8] = b[4*src+r];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input logic v, input logic inv, input logic [3:0] tag,
                      input logic [127:0] s4, input logic [255:0] s8,
                      input logic ordy, output logic acc);
    int           n;
    exp_t         e;
    logic [255:0] t4;
    @(negedge clk);
    if4.in_valid = v; if4.in_inv = inv; if4.in_tag = tag; if4.in_state = s4; if4.out_ready = ordy;
    if8.in_valid = v; if8.in_inv = inv; if8.in_tag = tag; if8.in_state = s8; if8.out_ready = ordy;
    n = q.size();
    check("in_ready4",  256'(if4.in_ready),  256'(n < 2));
    check("in_ready8",  256'(if8.in_ready),  256'(n < 2));
    check("out_valid4", 256'(if4.out_valid), 256'(n != 0));
    check("out_valid8", 256'(if8.out_valid), 256'(n != 0));
    if (n != 0) begin
      check("out_state4", 256'(if4.out_state), 256'(q[0].e4));
      check("out_tag4",   256'(if4.out_tag),   256'(q[0].tag));
      check("out_state8", if8.out_state,       q[0].e8);
      check("out_tag8",   256'(if8.out_tag),   256'(q[0].tag));
      if (ordy) begin
        popped.push_back(if4.out_tag);
        void'(q.pop_front());
      end
    end
    acc = v && (n < 2);
    if (acc) begin
      t4    = ref_sr(4, {128'b0, s4}, inv);
      e.tag = tag;
      e.e4  = t4[127:0];
      e.e8  = ref_sr(8, s8, inv);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, a);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic         acc, inv_t, v, ordy;
    logic [127:0] h4;
    logic [255:0] h8, bytes8;
    int           beats, cyc, tries;

    if4.in_valid = 0; if4.in_inv = 0; if4.in_tag = 0; if4.in_state = 0; if4.out_ready = 0;
    if8.in_valid = 0; if8.in_inv = 0; if8.in_tag = 0; if8.in_state = 0; if8.out_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 256'(if4.out_valid), 256'(0));
    check("rst_out_state", 256'(if4.out_state), 256'(0));
    check("rst_in_ready",  256'(if4.in_ready),  256'(1));
    rst_n = 1'b1;

    // FIPS-197 round 1 forward, then its inverse
    step(1'b1, 1'b0, 4'h5, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230, rnd256(), 1'b1, acc);
    @(posedge clk); #1;
    check("t1_fwd", 256'(if4.out_state), 256'(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5));
    check("t1_valid", 256'(if4.out_valid), 256'(1));
    step(1'b1, 1'b1, 4'h6, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, rnd256(), 1'b1, acc);
    @(posedge clk); #1;
    check("t2_inv", 256'(if4.out_state), 256'(128'hd42711ae_e0bf98f1_b8b45de5_1e415230));

    // NB=8 counting bytes, then invert the forward result back
    for (int k = 0; k < 32; k++) bytes8[255-8*k -: 8] = 8'(k);
    step(1'b1, 1'b0, 4'h7, rnd128(), bytes8, 1'b1, acc);
    @(posedge clk); #1;
    h8 = if8.out_state;
    check("t3_col0", 256'(h8[255:224]), 256'(32'h00050e13));
    step(1'b1, 1'b1, 4'h8, rnd128(), ref_sr(8, bytes8, 1'b0), 1'b1, acc);
    @(posedge clk); #1;
    check("t3_roundtrip", if8.out_state, bytes8);
    idle(3);

    // Backpressure: third beat must stall until the consumer drains
    popped.delete();
    step(1'b1, 1'b0, 4'h1, rnd128(), rnd256(), 1'b0, acc);
    step(1'b1, 1'b1, 4'h2, rnd128(), rnd256(), 1'b0, acc);
    @(posedge clk); #1;
    check("t4_full_ready", 256'(if4.in_ready), 256'(0));
    h4 = rnd128(); h8 = rnd256();
    step(1'b1, 1'b0, 4'h3, h4, h8, 1'b0, acc);
    step(1'b1, 1'b0, 4'h3, h4, h8, 1'b0, acc);
    check("t4_stall", 256'(acc), 256'(0));
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 10) begin
      step(1'b1, 1'b0, 4'h3, h4, h8, 1'b1, acc);
      tries++;
    end
    check("t4_accept", 256'(acc), 256'(1));
    idle(4);
    check("t4_count", 256'(popped.size()), 256'(3));
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check("t4_order", 256'(popped[i]), 256'(i + 1));

    // Random traffic with alternating direction
    beats = 0; cyc = 0; inv_t = 1'b0;
    while (beats < 10000 && cyc < 60000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, inv_t, 4'($urandom), rnd128(), rnd256(), ordy, acc);
      if (acc) begin
        beats++;
        inv_t = ~inv_t;
      end
      cyc++;
    end
    check("t5_beats", 256'(beats), 256'(10000));
    idle(3);

    // Reset while full drops both entries
    step(1'b1, 1'b0, 4'h9, rnd128(), rnd256(), 1'b0, acc);
    step(1'b1, 1'b1, 4'ha, rnd128(), rnd256(), 1'b0, acc);
    @(negedge clk);
    if4.in_valid = 0; if8.in_valid = 0;
    check("t6_pre_valid", 256'(if4.out_valid), 256'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid4", 256'(if4.out_valid), 256'(0));
    check("t6_rst_state4", 256'(if4.out_state), 256'(0));
    check("t6_rst_tag4",   256'(if4.out_tag),   256'(0));
    check("t6_rst_valid8", 256'(if8.out_valid), 256'(0));
    check("t6_rst_state8", if8.out_state,       256'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'hb, rnd128(), rnd256(), 1'b1, acc);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
